// File: rtl/sensor_ctrl_pkg.sv
// Shared types and constants for the multi-channel sensor capture controller.
package sensor_ctrl_pkg;

  // Per-channel capture state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } chan_state_e;

  // Values of sctrl_ring.
  localparam logic ONESHOT = 1'b0;
  localparam logic RING    = 1'b1;

  // Channel-select width: a single channel still gets one select bit.
  function automatic int calc_cw(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/sensor_ctrl_if.sv
// Core-side control/read bus of sensor_ctrl_mc.
// master = core/DMA side, slave = controller.
interface sensor_ctrl_if
  import sensor_ctrl_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DW    = 32,
  parameter int DEPTH = 4096
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = calc_cw(NCH);

  logic [NCH-1:0] sctrl_en;
  logic [NCH-1:0] sctrl_clear;
  logic           sctrl_ring;
  logic [AW:0]    sctrl_wmark;
  logic           sctrl_rd;
  logic [CW-1:0]  sctrl_ch;
  logic [AW-1:0]  sctrl_addr;
  logic [DW-1:0]  sctrl_out;
  logic           sctrl_rvalid;
  logic [AW:0]    sctrl_count;
  logic [NCH-1:0] sctrl_full;
  logic [NCH-1:0] sctrl_ovf;
  logic           sctrl_interrupt;

  modport master (
    output sctrl_en, sctrl_clear, sctrl_ring, sctrl_wmark,
    output sctrl_rd, sctrl_ch, sctrl_addr,
    input  sctrl_out, sctrl_rvalid, sctrl_count,
    input  sctrl_full, sctrl_ovf, sctrl_interrupt
  );

  modport slave (
    input  sctrl_en, sctrl_clear, sctrl_ring, sctrl_wmark,
    input  sctrl_rd, sctrl_ch, sctrl_addr,
    output sctrl_out, sctrl_rvalid, sctrl_count,
    output sctrl_full, sctrl_ovf, sctrl_interrupt
  );

endinterface

// File: rtl/sensor_ctrl_chan.sv
// One capture channel: FSM, write pointer, saturating count, sticky
// overflow and watermark compare. Emits the buffer write enable/address.
module sensor_ctrl_chan
  import sensor_ctrl_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        clear,
  input  logic        ready,
  input  logic        ring,
  input  logic [AW:0] wmark,
  output logic        we,
  output logic [AW-1:0] waddr,
  output logic [AW:0] count,
  output logic        full,
  output logic        ovf,
  output logic        wm,
  output chan_state_e state
);

  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  chan_state_e   state_next;
  logic [AW-1:0] wr_ptr;

  assign we    = (state == CAPTURE) && en && ready && !clear;
  assign waddr = wr_ptr;
  assign full  = (state == FULL);
  assign wm    = (wmark != '0) && (count >= wmark);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next state; clear wins over everything, FULL only leaves on clear.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (en) state_next = CAPTURE;
        CAPTURE: begin
          if (!en)
            state_next = IDLE;
          else if (we && (wr_ptr == LAST_PTR) && (ring == ONESHOT))
            state_next = FULL;
        end
        FULL:    state_next = FULL;
        default: state_next = IDLE;
      endcase
    end
  end

  // Pointer wraps naturally at DEPTH; count saturates; ovf is sticky in ring mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (we) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (count != DEPTH_CNT) count <= count + (AW + 1)'(1);
      if ((ring == RING) && (count == DEPTH_CNT)) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/sensor_ctrl_mc.sv
// Multi-channel sensor capture controller top: per-channel buffers,
// registered read port, interrupt OR and sensor enables.
// Build option: SENSOR_CTRL_MEM_RESET_EN resets every buffer entry to 0.
//
// Sensor handshake: sensor_ready[c] is "valid", sensor_en[c] is a
// permit. A sample is taken on a rising edge where the channel is in
// CAPTURE, sctrl_en[c] and sensor_ready[c] are high and sctrl_clear[c]
// is low. sensor_en is already high in the first enabled cycle out of
// IDLE, but that cycle only moves the FSM to CAPTURE; a sample offered
// while sensor_en is low is ignored.
module sensor_ctrl_mc
  import sensor_ctrl_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DW    = 32,
  parameter int DEPTH = 4096
) (
  input  logic                      clk,
  input  logic                      rstn,
  sensor_ctrl_if.slave              bus,
  input  logic [NCH-1:0]            sensor_ready,
  input  logic [NCH*DW-1:0]         sensor_out,
  output logic [NCH-1:0]            sensor_en,
  output logic [NCH*$bits(chan_state_e)-1:0] dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = calc_cw(NCH);
  localparam int SW = $bits(chan_state_e);

  logic [AW:0]    wmark_q;
  logic [NCH-1:0] we;
  logic [NCH-1:0] full;
  logic [NCH-1:0] ovf;
  logic [NCH-1:0] wm;
  logic [AW-1:0]  waddr [NCH];
  logic [AW:0]    count [NCH];
  chan_state_e    chan_state [NCH];
  logic [DW-1:0]  mem [NCH][DEPTH];
  logic [DW-1:0]  rd_data;
  logic [AW:0]    count_sel;
  logic [DW-1:0]  out_q;
  logic           rvalid_q;

  // Registered watermark keeps the interrupt free of input-to-output paths.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wmark_q <= '0;
    else       wmark_q <= bus.sctrl_wmark;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    sensor_ctrl_chan #(.DEPTH(DEPTH), .AW(AW)) u_chan (
      .clk   (clk),
      .rstn  (rstn),
      .en    (bus.sctrl_en[c]),
      .clear (bus.sctrl_clear[c]),
      .ready (sensor_ready[c]),
      .ring  (bus.sctrl_ring),
      .wmark (wmark_q),
      .we    (we[c]),
      .waddr (waddr[c]),
      .count (count[c]),
      .full  (full[c]),
      .ovf   (ovf[c]),
      .wm    (wm[c]),
      .state (chan_state[c])
    );
    assign dbg_state[c*SW +: SW] = chan_state[c];
  end

`ifdef SENSOR_CTRL_MEM_RESET_EN
  // Buffer write with full reset of every entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NCH; c++)
        for (int a = 0; a < DEPTH; a++)
          mem[c][a] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (we[c]) mem[c][waddr[c]] <= sensor_out[c*DW +: DW];
    end
  end
`else
  // Buffer write, no reset so the array can map onto RAM.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++)
      if (we[c]) mem[c][waddr[c]] <= sensor_out[c*DW +: DW];
  end
`endif

  // Channel select mux for read data and count; unmatched selects give 0.
  always_comb begin
    rd_data   = '0;
    count_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (bus.sctrl_ch == CW'(c)) begin
        rd_data   = mem[c][bus.sctrl_addr];
        count_sel = count[c];
      end
    end
  end

  // Read register; a same-edge write to the same slot is not yet visible.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= bus.sctrl_rd;
      if (bus.sctrl_rd) out_q <= rd_data;
    end
  end

  assign bus.sctrl_out       = out_q;
  assign bus.sctrl_rvalid    = rvalid_q;
  assign bus.sctrl_count     = count_sel;
  assign bus.sctrl_full      = full;
  assign bus.sctrl_ovf       = ovf;
  assign bus.sctrl_interrupt = |(full | wm | ovf);
  assign sensor_en           = bus.sctrl_en & ~full & ~bus.sctrl_clear;

endmodule

// File: tb/tb_sensor_ctrl_mc.sv
// Bench for sensor_ctrl_mc (NCH=2, DEPTH=16, DW=32): directed scenarios
// followed by random traffic, all checked against a behavioural model.
`timescale 1ns/1ps
module tb_sensor_ctrl_mc;
  import sensor_ctrl_pkg::*;

  localparam int NCH   = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]      sensor_ready;
  logic [NCH*DW-1:0]   sensor_out;
  logic [NCH-1:0]      sensor_en;
  logic [2*NCH-1:0]    dbg_state;

  sensor_ctrl_if #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) bus_if ();

  sensor_ctrl_mc #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus_if),
    .sensor_ready (sensor_ready),
    .sensor_out   (sensor_out),
    .sensor_en    (sensor_en),
    .dbg_state    (dbg_state)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem   [NCH][DEPTH];
  bit            m_known [NCH][DEPTH];
  int            m_ptr [NCH];
  int            m_cnt [NCH];
  int            m_nwr [NCH];
  bit            m_full [NCH];
  bit            m_ovf [NCH];
  bit            m_act [NCH];
  int            m_wmark;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  bit            known_q[$];
  logic [DW-1:0] last_out;
  bit            last_known;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ptr[c] = 0; m_cnt[c] = 0; m_full[c] = 0; m_ovf[c] = 0; m_act[c] = 0;
      for (int a = 0; a < DEPTH; a++) begin
`ifdef SENSOR_CTRL_MEM_RESET_EN
        m_mem[c][a] = '0;
        m_known[c][a] = 1;
`else
        m_known[c][a] = 0;
`endif
      end
    end
    m_wmark = 0;
    exp_q.delete();
    known_q.delete();
    last_out = '0;
    last_known = 1;
  endtask

  // One clock edge of the specified behaviour, from the inputs present at it.
  task automatic model_step();
    int ch;
    int a;
    bit en;
    bit rdy;
    bit clr;
    bit ring;
    ring = bus_if.sctrl_ring;
    if (bus_if.sctrl_rd) begin
      ch = int'(bus_if.sctrl_ch);
      a  = int'(bus_if.sctrl_addr);
      if (ch >= NCH) begin
        exp_q.push_back('0);
        known_q.push_back(1);
      end else begin
        exp_q.push_back(m_mem[ch][a]);
        known_q.push_back(m_known[ch][a]);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      en  = bus_if.sctrl_en[c];
      rdy = sensor_ready[c];
      clr = bus_if.sctrl_clear[c];
      if (clr) begin
        m_ptr[c] = 0; m_cnt[c] = 0; m_ovf[c] = 0; m_full[c] = 0; m_act[c] = 0;
      end else if (m_act[c] && en && rdy) begin
        m_mem[c][m_ptr[c]]   = sensor_out[c*DW +: DW];
        m_known[c][m_ptr[c]] = 1;
        m_nwr[c]++;
        if (ring && m_cnt[c] == DEPTH) m_ovf[c] = 1;
        if (m_cnt[c] < DEPTH) m_cnt[c]++;
        if (m_ptr[c] == DEPTH - 1 && !ring) begin
          m_full[c] = 1;
          m_act[c]  = 0;
        end
        m_ptr[c] = (m_ptr[c] + 1) % DEPTH;
      end else if (!m_full[c]) begin
        m_act[c] = en;
      end
    end
    m_wmark = int'(bus_if.sctrl_wmark);
  endtask

  // Compare every observable output with the model.
  task automatic compare_all();
    int ch;
    bit irq;
    bit exp_en;
    logic [DW-1:0] e;
    bit k;
    ch  = int'(bus_if.sctrl_ch);
    irq = 0;
    check("count", 32'(bus_if.sctrl_count), (ch < NCH) ? 32'(m_cnt[ch]) : 32'd0);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("full%0d", c), 32'(bus_if.sctrl_full[c]), 32'(m_full[c]));
      check($sformatf("ovf%0d", c), 32'(bus_if.sctrl_ovf[c]), 32'(m_ovf[c]));
      exp_en = bus_if.sctrl_en[c] && !m_full[c] && !bus_if.sctrl_clear[c];
      check($sformatf("sensor_en%0d", c), 32'(sensor_en[c]), 32'(exp_en));
      if (m_full[c] || m_ovf[c] || (m_wmark != 0 && m_cnt[c] >= m_wmark)) irq = 1;
    end
    check("irq", 32'(bus_if.sctrl_interrupt), 32'(irq));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      k = known_q.pop_front();
      check("rvalid", 32'(bus_if.sctrl_rvalid), 32'd1);
      if (k) check("rdata", bus_if.sctrl_out, e);
      last_out = e;
      last_known = k;
    end else begin
      check("rvalid", 32'(bus_if.sctrl_rvalid), 32'd0);
      if (last_known) check("rhold", bus_if.sctrl_out, last_out);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    if (rstn) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic capture(input int c, input int n, input logic [DW-1:0] base);
    int start;
    int budget;
    start  = m_nwr[c];
    budget = 4 * n + 8;
    bus_if.sctrl_en[c] = 1'b1;
    sensor_ready[c] = 1'b1;
    while ((m_nwr[c] - start) < n && budget > 0) begin
      sensor_out[c*DW +: DW] = base + DW'(m_nwr[c] - start);
      tick();
      budget--;
    end
    sensor_ready[c] = 1'b0;
    if ((m_nwr[c] - start) < n) check("cap_timeout", 32'(m_nwr[c] - start), 32'(n));
  endtask

  task automatic clear_ch(input int c);
    bus_if.sctrl_clear[c] = 1'b1;
    tick();
    bus_if.sctrl_clear[c] = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int ch, input int a, input logic [DW-1:0] exp);
    bus_if.sctrl_rd   = 1'b1;
    bus_if.sctrl_ch   = 1'(ch);
    bus_if.sctrl_addr = AW'(a);
    tick();
    bus_if.sctrl_rd = 1'b0;
    check(tag, bus_if.sctrl_out, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_if.sctrl_en    = '0;
    bus_if.sctrl_clear = '0;
    bus_if.sctrl_ring  = ONESHOT;
    bus_if.sctrl_wmark = '0;
    bus_if.sctrl_rd    = 1'b0;
    bus_if.sctrl_ch    = '0;
    bus_if.sctrl_addr  = '0;
    sensor_ready = '0;
    sensor_out   = '0;
    for (int c = 0; c < NCH; c++) m_nwr[c] = 0;
    model_reset();
    tick();
    tick();
    rstn = 1'b1;

    check("rst_count", 32'(bus_if.sctrl_count), 32'd0);
    check("rst_full", 32'(bus_if.sctrl_full), 32'd0);
    check("rst_ovf", 32'(bus_if.sctrl_ovf), 32'd0);
    check("rst_rvalid", 32'(bus_if.sctrl_rvalid), 32'd0);
    check("rst_out", bus_if.sctrl_out, 32'd0);
    check("rst_irq", 32'(bus_if.sctrl_interrupt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // One-shot fill of channel 0.
    capture(0, 16, 32'h100);
    check("fill_full", 32'(bus_if.sctrl_full[0]), 32'd1);
    check("fill_count", 32'(bus_if.sctrl_count), 32'd16);
    check("fill_irq", 32'(bus_if.sctrl_interrupt), 32'd1);
    check("fill_sen", 32'(sensor_en[0]), 32'd0);
    check("fill_state", 32'(dbg_state[1:0]), 32'(FULL));
    for (int i = 0; i < 16; i++)
      read_chk($sformatf("fill_rd%0d", i), 0, i, 32'h100 + 32'(i));

    // Clear on a FULL channel with a sample offered in the same cycle.
    sensor_ready[0] = 1'b1;
    sensor_out[31:0] = 32'hDEAD;
    clear_ch(0);
    sensor_ready[0] = 1'b0;
    check("clr_count", 32'(bus_if.sctrl_count), 32'd0);
    check("clr_full", 32'(bus_if.sctrl_full[0]), 32'd0);
    check("clr_state", 32'(dbg_state[1:0]), 32'(IDLE));
    capture(0, 1, 32'hC0DE);
    read_chk("clr_addr0", 0, 0, 32'hC0DE);
    read_chk("clr_keep1", 0, 1, 32'h101);
    check("clr_count1", 32'(bus_if.sctrl_count), 32'd1);
    bus_if.sctrl_en[0] = 1'b0;
    clear_ch(0);

    // Watermark.
    bus_if.sctrl_wmark = 5'(5);
    capture(0, 4, 32'h500);
    check("wm_below", 32'(bus_if.sctrl_interrupt), 32'd0);
    capture(0, 1, 32'h504);
    check("wm_hit", 32'(bus_if.sctrl_interrupt), 32'd1);
    bus_if.sctrl_wmark = '0;
    tick();
    check("wm_off", 32'(bus_if.sctrl_interrupt), 32'd0);
    capture(0, 11, 32'h505);
    check("wm_off_full", 32'(bus_if.sctrl_interrupt), 32'd1);
    bus_if.sctrl_en[0] = 1'b0;
    clear_ch(0);

    // Ring wrap on channel 1.
    bus_if.sctrl_ring = RING;
    capture(1, 20, 32'd0);
    bus_if.sctrl_en[1] = 1'b0;
    bus_if.sctrl_ch = 1'b1;
    tick();
    check("ring_count", 32'(bus_if.sctrl_count), 32'd16);
    check("ring_ovf", 32'(bus_if.sctrl_ovf[1]), 32'd1);
    check("ring_full", 32'(bus_if.sctrl_full[1]), 32'd0);
    for (int i = 0; i < 4; i++)
      read_chk($sformatf("ring_rd%0d", i), 1, i, 32'(16 + i));
    read_chk("ring_rd4", 1, 4, 32'd4);
    clear_ch(1);
    bus_if.sctrl_ring = ONESHOT;
    bus_if.sctrl_ch = 1'b0;

    // Read/write collision on ch0 addr2.
    capture(0, 3, 32'hA8);
    clear_ch(0);
    capture(0, 2, 32'h0);
    sensor_out[31:0]  = 32'hBB;
    sensor_ready[0]   = 1'b1;
    bus_if.sctrl_rd   = 1'b1;
    bus_if.sctrl_ch   = 1'b0;
    bus_if.sctrl_addr = AW'(2);
    tick();
    sensor_ready[0] = 1'b0;
    bus_if.sctrl_rd = 1'b0;
    check("coll_old", bus_if.sctrl_out, 32'hAA);
    read_chk("coll_new", 0, 2, 32'hBB);
    bus_if.sctrl_en[0] = 1'b0;
    clear_ch(0);

    // Asynchronous reset in the middle of a capture.
    capture(0, 7, 32'h700);
    check("pre_rst_count", 32'(bus_if.sctrl_count), 32'd7);
    read_chk("pre_rst_rd", 0, 0, 32'h700);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check("arst_count", 32'(bus_if.sctrl_count), 32'd0);
    check("arst_full", 32'(bus_if.sctrl_full), 32'd0);
    check("arst_ovf", 32'(bus_if.sctrl_ovf), 32'd0);
    check("arst_rvalid", 32'(bus_if.sctrl_rvalid), 32'd0);
    check("arst_out", bus_if.sctrl_out, 32'd0);
    check("arst_irq", 32'(bus_if.sctrl_interrupt), 32'd0);
    bus_if.sctrl_en = '0;
    sensor_ready = '0;
    tick();
    tick();
    rstn = 1'b1;
`ifdef SENSOR_CTRL_MEM_RESET_EN
    for (int i = 0; i < 7; i++)
      read_chk($sformatf("arst_mem%0d", i), 0, i, 32'd0);
`endif

    // Random traffic, one segment per mode.
    for (int seg = 0; seg < 2; seg++) begin
      bus_if.sctrl_ring  = (seg == 0) ? ONESHOT : RING;
      bus_if.sctrl_clear = '1;
      tick();
      bus_if.sctrl_clear = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        for (int c = 0; c < NCH; c++) begin
          if ($urandom_range(0, 15) == 0) bus_if.sctrl_en[c] = ~bus_if.sctrl_en[c];
          sensor_ready[c] = ($urandom_range(0, 3) != 0);
          bus_if.sctrl_clear[c] = ($urandom_range(0, 47) == 0);
          sensor_out[c*DW +: DW] = $urandom;
        end
        if ($urandom_range(0, 49) == 0) bus_if.sctrl_wmark = 5'($urandom_range(0, DEPTH));
        bus_if.sctrl_rd   = 1'($urandom_range(0, 1));
        bus_if.sctrl_ch   = 1'($urandom_range(0, NCH - 1));
        bus_if.sctrl_addr = AW'($urandom_range(0, DEPTH - 1));
        tick();
      end
      bus_if.sctrl_en = '0;
      bus_if.sctrl_clear = '0;
      bus_if.sctrl_rd = 1'b0;
      sensor_ready = '0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
